// File: rtl/ads131a0x_spi_responder.sv
// SPI device-side responder for an ADS131A0x-style ADC: each frame streams a response word and
// the channel samples, while the first word from the master is executed as a command.
module ads131a0x_spi_responder #(
   parameter int unsigned WORD_BITS = 16,
   parameter int unsigned CHANNELS  = 4
) (
   input  logic                          system_clock,
   input  logic                          reset_n,
   input  logic                          SPI_SCLK,
   input  logic                          SPI_CS,
   input  logic                          SPI_MOSI,
   output logic                          SPI_MISO,
   input  logic                          SPI_RESET,
   input  logic [CHANNELS*WORD_BITS-1:0] ch_data,
   input  logic                          sample_strobe,
   output logic                          drdy_n,
   output logic                          locked,
   output logic                          cmd_valid,
   output logic [WORD_BITS-1:0]          cmd_word,
   output logic                          frame_abort
);

   localparam int unsigned FrameBits = (1 + CHANNELS) * WORD_BITS;
   localparam int unsigned CntW      = $clog2(FrameBits + 1);

   localparam logic [CntW-1:0]      CmdBits      = CntW'(WORD_BITS);
   localparam logic [CntW-1:0]      LastCmdBit   = CntW'(WORD_BITS - 1);
   localparam logic [CntW-1:0]      LastFrameBit = CntW'(FrameBits - 1);
   localparam logic [WORD_BITS-1:0] CmdReset     = WORD_BITS'(16'h0011);
   localparam logic [WORD_BITS-1:0] CmdUnlock    = WORD_BITS'(16'h0655);
   localparam logic [WORD_BITS-1:0] CmdLock      = WORD_BITS'(16'h0555);
   localparam logic [WORD_BITS-1:0] RespReset    = WORD_BITS'(16'hFF04);

   typedef enum logic [1:0] {StIdle, StShift, StOverrun} state_e;

   state_e                 state_q;
   logic [FrameBits-1:0]   shift_q;
   logic [FrameBits-1:0]   frame_load;
   logic [CntW-1:0]        bit_cnt_q;
   logic [WORD_BITS-2:0]   cmd_sh_q;
   logic [WORD_BITS-1:0]   resp_q;
   logic [7:0]             regs_q [32];

   logic [2:0] sclk_sync, cs_sync;
   logic [1:0] mosi_sync, rst_sync;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit, dev_reset;

   // Third stage of SCLK/CS only serves edge detection.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
         rst_sync  <= 2'b11;
      end else begin
         sclk_sync <= {sclk_sync[1:0], SPI_SCLK};
         cs_sync   <= {cs_sync[1:0], SPI_CS};
         mosi_sync <= {mosi_sync[0], SPI_MOSI};
         rst_sync  <= {rst_sync[0], SPI_RESET};
      end
   end

   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign cs_fall   = ~cs_sync[1] & cs_sync[2];
   assign cs_rise   = cs_sync[1] & ~cs_sync[2];
   assign mosi_bit  = mosi_sync[1];
   assign dev_reset = ~rst_sync[1];

   // Response in the top word, then channel 0 .. CHANNELS-1.
   always_comb begin
      frame_load = '0;
      frame_load[FrameBits-1 -: WORD_BITS] = resp_q;
      for (int k = 0; k < int'(CHANNELS); k++) begin
         frame_load[(int'(CHANNELS) - 1 - k) * int'(WORD_BITS) +: WORD_BITS] =
            ch_data[k * int'(WORD_BITS) +: WORD_BITS];
      end
   end

   logic [2:0]           opcode;
   logic [4:0]           addr;
   logic [7:0]           wdata;
   logic [WORD_BITS-1:0] exec_resp;
   logic                 exec_lock, exec_wr, exec_clr;

   assign opcode = cmd_word[WORD_BITS-1 -: 3];
   assign addr   = cmd_word[WORD_BITS-4 -: 5];
   assign wdata  = cmd_word[7:0];

   always_comb begin
      exec_resp = WORD_BITS'({8'h22, regs_q[2]});
      exec_lock = locked;
      exec_wr   = 1'b0;
      exec_clr  = 1'b0;
      if (cmd_word == CmdReset) begin
         exec_resp = RespReset;
         exec_lock = 1'b1;
         exec_clr  = 1'b1;
      end else if (cmd_word == CmdUnlock) begin
         exec_resp = CmdUnlock;
         exec_lock = 1'b0;
      end else if (cmd_word == CmdLock) begin
         exec_resp = CmdLock;
         exec_lock = 1'b1;
      end else if (opcode == 3'b001) begin
         exec_resp = WORD_BITS'({3'b001, addr, regs_q[addr]});
      end else if (opcode == 3'b010 && !locked) begin
         exec_resp = WORD_BITS'({3'b001, addr, wdata});
         exec_wr   = 1'b1;
      end
   end

   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         cmd_sh_q    <= '0;
         resp_q      <= RespReset;
         SPI_MISO    <= 1'b0;
         drdy_n      <= 1'b1;
         locked      <= 1'b1;
         cmd_valid   <= 1'b0;
         cmd_word    <= '0;
         frame_abort <= 1'b0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
      end else begin
         cmd_valid   <= 1'b0;
         frame_abort <= 1'b0;
         if (cs_fall) begin
            drdy_n <= 1'b1;
         end else if (sample_strobe) begin
            drdy_n <= 1'b0;
         end

         if (dev_reset) begin
            state_q   <= StIdle;
            SPI_MISO  <= 1'b0;
            resp_q    <= RespReset;
            locked    <= 1'b1;
            bit_cnt_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
         end else if (cs_rise) begin
            state_q  <= StIdle;
            SPI_MISO <= 1'b0;
            if (state_q != StIdle) begin
               if (bit_cnt_q >= CmdBits) begin
                  resp_q <= exec_resp;
                  locked <= exec_lock;
                  if (exec_clr) begin
                     for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
                  end else if (exec_wr) begin
                     regs_q[addr] <= wdata;
                  end
               end else begin
                  frame_abort <= 1'b1;
               end
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  SPI_MISO <= 1'b0;
                  if (cs_fall) begin
                     state_q   <= StShift;
                     shift_q   <= frame_load;
                     bit_cnt_q <= '0;
                  end
               end
               StShift: begin
                  if (sclk_rise) begin
                     SPI_MISO <= shift_q[FrameBits-1];
                     shift_q  <= {shift_q[FrameBits-2:0], 1'b0};
                  end
                  if (sclk_fall) begin
                     bit_cnt_q <= bit_cnt_q + CntW'(1);
                     if (bit_cnt_q < CmdBits) cmd_sh_q <= {cmd_sh_q[WORD_BITS-3:0], mosi_bit};
                     if (bit_cnt_q == LastCmdBit) begin
                        cmd_word  <= {cmd_sh_q, mosi_bit};
                        cmd_valid <= 1'b1;
                     end
                     if (bit_cnt_q == LastFrameBit) begin
                        state_q  <= StOverrun;
                        SPI_MISO <= 1'b0;
                     end
                  end
               end
               StOverrun: SPI_MISO <= 1'b0;
               default:   state_q  <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ads131a0x_spi_responder.sv
// Randomised SPI-master bench for ads131a0x_spi_responder, checked against a command-level
// model of the response word, lock flag and register file.
module tb_ads131a0x_spi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b0;
   logic        spi_rst = 1'b1;
   logic        strobe = 1'b0;
   logic [63:0] ch_data = '0;
   logic        miso, drdy_n, locked, cmd_valid, frame_abort;
   logic [15:0] cmd_word;

   int vectors = 0;
   int errors = 0;
   int n_valid = 0;
   int n_abort = 0;

   logic [15:0] m_resp;
   logic        m_locked;
   logic [7:0]  m_regs [32];

   always #10 clk = ~clk;

   ads131a0x_spi_responder #(.WORD_BITS(16), .CHANNELS(4)) dut (
      .system_clock (clk),
      .reset_n      (rst_n),
      .SPI_SCLK     (sclk),
      .SPI_CS       (cs),
      .SPI_MOSI     (mosi),
      .SPI_MISO     (miso),
      .SPI_RESET    (spi_rst),
      .ch_data      (ch_data),
      .sample_strobe(strobe),
      .drdy_n       (drdy_n),
      .locked       (locked),
      .cmd_valid    (cmd_valid),
      .cmd_word     (cmd_word),
      .frame_abort  (frame_abort)
   );

   always @(negedge clk) begin
      if (cmd_valid) n_valid <= n_valid + 1;
      if (frame_abort) n_abort <= n_abort + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_resp   = 16'hFF04;
      m_locked = 1'b1;
      for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
   endtask

   task automatic model_exec(input logic [15:0] c);
      if (c == 16'h0011) model_reset();
      else if (c == 16'h0655) begin
         m_resp = 16'h0655; m_locked = 1'b0;
      end else if (c == 16'h0555) begin
         m_resp = 16'h0555; m_locked = 1'b1;
      end else if (c[15:13] == 3'b001) m_resp = {3'b001, c[12:8], m_regs[c[12:8]]};
      else if (c[15:13] == 3'b010 && !m_locked) begin
         m_regs[c[12:8]] = c[7:0];
         m_resp = {3'b001, c[12:8], c[7:0]};
      end else m_resp = {8'h22, m_regs[2]};
   endtask

   // One SCLK period: master launches MOSI on the rise and samples MISO before the fall.
   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      r = miso;
      sclk = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic spi_frame(input logic [15:0] c, input int nbits, input logic [63:0] ch,
                            output logic [127:0] got);
      logic r;
      got = '0;
      ch_data = ch;
      cs = 1'b0;
      repeat (6) @(negedge clk);
      ch_data = ~ch;  // must not leak into the frame already latched
      for (int i = 0; i < nbits; i++) begin
         spi_bit((i < 16) ? c[15-i] : 1'($urandom_range(0, 1)), r);
         got[127-i] = r;
      end
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic run_frame(input logic [15:0] c, input int nbits, input logic [63:0] ch);
      logic [127:0] got;
      logic [15:0]  exp;
      logic         ovr;
      int           v0, a0;
      v0 = n_valid;
      a0 = n_abort;
      spi_frame(c, nbits, ch, got);
      for (int wd = 0; wd < 5; wd++) begin
         if (wd * 16 + 16 <= nbits) begin
            exp = (wd == 0) ? m_resp : ch[(wd-1)*16 +: 16];
            check($sformatf("word%0d cmd %h", wd, c), 64'(got[127-wd*16 -: 16]), 64'(exp));
         end
      end
      if (nbits > 80) begin
         ovr = 1'b0;
         for (int i = 80; i < nbits; i++) ovr |= got[127-i];
         check("overrun_miso", 64'(ovr), 64'd0);
      end
      if (nbits >= 16) begin
         check("cmd_word", 64'(cmd_word), 64'(c));
         check("cmd_valid_pulses", 64'(n_valid - v0), 64'd1);
         check("no_abort", 64'(n_abort - a0), 64'd0);
         model_exec(c);
      end else begin
         check("short_abort", 64'(n_abort - a0), 64'd1);
         check("short_no_valid", 64'(n_valid - v0), 64'd0);
      end
      check("locked", 64'(locked), 64'(m_locked));
      check("drdy_high_after_frame", 64'(drdy_n), 64'd1);
   endtask

   function automatic logic [15:0] rand_cmd();
      logic [4:0]  a;
      logic [15:0] c;
      a = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
         0:       c = 16'h0011;
         1, 2:    c = 16'h0655;
         3:       c = 16'h0555;
         4, 5:    c = {3'b001, a, 8'($urandom)};
         6, 7, 8: c = {3'b010, a, 8'($urandom)};
         default: c = 16'($urandom);
      endcase
      return c;
   endfunction

   initial begin
      logic r;
      logic any;
      int   a0, nb;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_miso", 64'(miso), 64'd0);
      check("rst_drdy", 64'(drdy_n), 64'd1);
      check("rst_locked", 64'(locked), 64'd1);
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_word", 64'(cmd_word), 64'd0);
      check("rst_abort", 64'(frame_abort), 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      run_frame(16'h0000, 80, 64'h4444_3333_2222_1111);
      run_frame(16'h0655, 80, {$urandom, $urandom});
      run_frame(16'h0000, 80, {$urandom, $urandom});
      run_frame(16'h0555, 80, {$urandom, $urandom});
      run_frame(16'h4B3C, 80, {$urandom, $urandom});
      run_frame(16'h0655, 80, {$urandom, $urandom});
      run_frame(16'h4B3C, 80, {$urandom, $urandom});
      run_frame(16'h2B00, 80, {$urandom, $urandom});
      run_frame(16'h0555, 9, {$urandom, $urandom});
      run_frame(16'h0000, 80, {$urandom, $urandom});

      // Device reset through SPI_RESET in the middle of a frame.
      ch_data = 64'h0000_0000_0000_FFFF;
      cs = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 20; i++) spi_bit(1'b0, r);
      check("miso_before_spi_reset", 64'(r), 64'd1);
      spi_rst = 1'b0;
      repeat (4) @(negedge clk);
      check("miso_at_spi_reset", 64'(miso), 64'd0);
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spi_bit(1'b1, r);
         any |= r;
      end
      check("miso_during_spi_reset", 64'(any), 64'd0);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      spi_rst = 1'b1;
      repeat (8) @(negedge clk);
      model_reset();
      check("locked_after_spi_reset", 64'(locked), 64'd1);
      run_frame(16'h2B00, 80, {$urandom, $urandom});
      run_frame(16'h0000, 80, {$urandom, $urandom});

      // drdy_n: strobe alone, then strobe colliding with the synchronised CS fall.
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      check("drdy_after_strobe", 64'(drdy_n), 64'd0);
      a0 = n_abort;
      cs = 1'b0;
      repeat (2) @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      check("drdy_cs_wins", 64'(drdy_n), 64'd1);
      repeat (4) @(negedge clk);
      check("drdy_held", 64'(drdy_n), 64'd1);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      check("drdy_next_strobe", 64'(drdy_n), 64'd0);
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      check("empty_frame_abort", 64'(n_abort - a0), 64'd1);

      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 9))
            0:       nb = $urandom_range(1, 15);
            1:       nb = 84;
            default: nb = 80;
         endcase
         run_frame(rand_cmd(), nb, {$urandom, $urandom});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
